// File: rtl/prog_loader_if.sv
// Stream-in and fetch-out signal bundle for the program loader.
// master: the side that feeds program bytes and issues fetches.
// slave: the loader itself.
interface prog_loader_if #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic              fetch_en;
   logic [ADDR_W-1:0] fetch_addr;
   logic [DATA_W-1:0] fetch_data;
   logic              fetch_valid;

   modport master (
      output in_data, in_valid, fetch_en, fetch_addr,
      input  in_ready, fetch_data, fetch_valid
   );

   modport slave (
      input  in_data, in_valid, fetch_en, fetch_addr,
      output in_ready, fetch_data, fetch_valid
   );
endinterface

// File: rtl/prog_loader.sv
// Program loader for the tiny accumulator processor.
// Accepts a length-prefixed, checksummed byte stream, stores it in a small
// instruction RAM (unused slots hold the halt opcode), and keeps the
// processor disabled until a load completes with a good checksum. While
// running, the RAM serves instruction fetches with one cycle of latency.
module prog_loader #(
   parameter int                ADDR_W  = 4,
   parameter int                DATA_W  = 8,
   parameter logic [DATA_W-1:0] HALT_OP = 8'h0F
) (
   input  logic              clk,
   input  logic              pc_reset,
   input  logic              load_start,
   prog_loader_if.slave      bus,
   output logic              run,
   output logic              busy,
   output logic              error,
   output logic [ADDR_W:0]   load_count
);

   localparam int                DEPTH   = 2 ** ADDR_W;
   localparam logic [DATA_W-1:0] DEPTH_B = DATA_W'(DEPTH);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      LEN   = 3'd2,
      DATA  = 3'd3,
      CSUM  = 3'd4,
      RUN   = 3'd5,
      ERROR = 3'd6
   } state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] clear_ptr_reg, clear_ptr_next;
   logic [ADDR_W:0]   count_reg, count_next;
   logic [ADDR_W:0]   count_inc;
   logic [ADDR_W:0]   len_reg, len_next;
   logic [DATA_W-1:0] acc_reg, acc_next;
   logic [DATA_W-1:0] sum_byte;

   logic              in_ready_reg;
   logic              run_reg;
   logic              busy_reg;
   logic              error_reg;
   logic              fetch_valid_reg;
   logic [DATA_W-1:0] fetch_data_reg;

   logic              accept;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [DATA_W-1:0] ram_wdata;

   logic [DATA_W-1:0] ram [DEPTH];

   // in_ready is a registered decode of the state, so a transfer is simply
   // in_valid during a cycle in which in_ready is already high.
   assign accept    = bus.in_valid && in_ready_reg;
   assign count_inc = count_reg + 1'b1;
   assign sum_byte  = acc_reg + bus.in_data;

   // Next-state, RAM write port and loader bookkeeping.
   always_comb begin
      state_next     = state_reg;
      clear_ptr_next = clear_ptr_reg;
      count_next     = count_reg;
      len_next       = len_reg;
      acc_next       = acc_reg;
      ram_we         = 1'b0;
      ram_waddr      = clear_ptr_reg;
      ram_wdata      = HALT_OP;

      case (state_reg)
         IDLE, RUN, ERROR: begin
            if (load_start) begin
               state_next     = CLEAR;
               clear_ptr_next = '0;
               count_next     = '0;
               acc_next       = '0;
            end
         end

         CLEAR: begin
            // Wipe every slot to halt so a short program ends cleanly.
            ram_we         = 1'b1;
            ram_waddr      = clear_ptr_reg;
            ram_wdata      = HALT_OP;
            clear_ptr_next = clear_ptr_reg + 1'b1;
            if (clear_ptr_reg == '1) begin
               state_next = LEN;
            end
         end

         LEN: begin
            if (accept) begin
               if ((bus.in_data != '0) && (bus.in_data <= DEPTH_B)) begin
                  len_next   = bus.in_data[ADDR_W:0];
                  count_next = '0;
                  state_next = DATA;
               end else begin
                  state_next = ERROR;
               end
            end
         end

         DATA: begin
            if (accept) begin
               ram_we     = 1'b1;
               ram_waddr  = count_reg[ADDR_W-1:0];
               ram_wdata  = bus.in_data;
               count_next = count_inc;
               acc_next   = sum_byte;
               if (count_inc == len_reg) begin
                  state_next = CSUM;
               end
            end
         end

         CSUM: begin
            if (accept) begin
               if (sum_byte == '0) begin
                  state_next = RUN;
               end else begin
                  state_next = ERROR;
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and loader registers; status outputs are decoded from the next state
   // so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (pc_reset) begin
         state_reg     <= IDLE;
         clear_ptr_reg <= '0;
         count_reg     <= '0;
         len_reg       <= '0;
         acc_reg       <= '0;
         in_ready_reg  <= 1'b0;
         run_reg       <= 1'b0;
         busy_reg      <= 1'b0;
         error_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         clear_ptr_reg <= clear_ptr_next;
         count_reg     <= count_next;
         len_reg       <= len_next;
         acc_reg       <= acc_next;
         in_ready_reg  <= (state_next == LEN) || (state_next == DATA) ||
                          (state_next == CSUM);
         run_reg       <= (state_next == RUN);
         busy_reg      <= (state_next == CLEAR) || (state_next == LEN) ||
                          (state_next == DATA) || (state_next == CSUM);
         error_reg     <= (state_next == ERROR);
      end
   end

   // Instruction RAM write port; contents survive reset on purpose.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram[ram_waddr] <= ram_wdata;
      end
   end

   // Registered fetch port. A fetch arriving with load_start is dropped
   // because the processor is being taken out of RUN on that same edge.
   always_ff @(posedge clk) begin
      if (pc_reset) begin
         fetch_valid_reg <= 1'b0;
         fetch_data_reg  <= HALT_OP;
      end else if (state_next != RUN) begin
         fetch_valid_reg <= 1'b0;
         fetch_data_reg  <= HALT_OP;
      end else if ((state_reg == RUN) && bus.fetch_en) begin
         fetch_valid_reg <= 1'b1;
         fetch_data_reg  <= ram[bus.fetch_addr];
      end else begin
         fetch_valid_reg <= 1'b0;
      end
   end

   assign bus.in_ready    = in_ready_reg;
   assign bus.fetch_valid = fetch_valid_reg;
   assign bus.fetch_data  = fetch_data_reg;
   assign run             = run_reg;
   assign busy            = busy_reg;
   assign error           = error_reg;
   assign load_count      = count_reg;

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream stage of the tiny accumulator processor: receives a program as a byte stream, validates it, stores it in a 16x8 instruction RAM.
- Serves instruction bytes to the processor's fetch by PC address.
- Holds the processor in reset (`run`=0) until a complete program with a correct checksum is loaded.
- Unloaded slots read as the halt opcode.

Parameters:
- ADDR_W, 4, instruction address width (depth = 2**ADDR_W = 16)
- DATA_W, 8, instruction width
- HALT_OP, 8'h0F, fill value for unused slots (processor halt opcode)

Ports:
- clk  input  1  system clock; all logic on rising edge
- pc_reset  input  1  synchronous, active-high reset
- load_start  input  1  pulse; begins a new load (honoured in IDLE, RUN, ERROR only)
- in_data  input  8  program stream byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts byte; transfer when in_valid && in_ready
- fetch_en  input  1  read request from processor
- fetch_addr  input  4  PC value to read
- fetch_data  output  8  registered instruction byte
- fetch_valid  output  1  fetch_data valid (one cycle after accepted fetch_en)
- run  output  1  processor enable; high only in RUN
- busy  output  1  high in CLEAR or LOAD
- error  output  1  sticky load failure flag
- load_count  output  5  instruction bytes stored in current/last load (0..16)

Behaviour:
- Reset (pc_reset=1 at edge): state=IDLE, run=0, busy=0, error=0, in_ready=0, fetch_valid=0, fetch_data=HALT_OP, load_count=0; RAM contents not reset. Reset overrides everything, including mid-CLEAR/LOAD.
- States: IDLE, CLEAR, LEN, DATA, CSUM, RUN, ERROR.
- IDLE/RUN/ERROR + load_start -> CLEAR:
  - clears error, run, load_count, checksum accumulator.
  - load_start in CLEAR/LEN/DATA/CSUM is ignored.
- CLEAR:
  - writes HALT_OP to addresses 0..15, one per cycle: exactly 16 cycles, in_ready=0.
  - then -> LEN.
- LEN: in_ready=1; accepted byte is N.
  - N in 1..16 -> DATA, write pointer=0.
  - N=0 or N>16 -> ERROR.
- DATA: in_ready=1; each accepted byte:
  - written to RAM[ptr]; ptr++, load_count++; acc = acc + byte (mod 256).
  - after N-th byte -> CSUM.
- CSUM: in_ready=1; accepted byte C.
  - (acc + C) mod 256 == 0 -> RUN.
  - otherwise -> ERROR.
- RUN: run=1, in_ready=0.
- ERROR: error=1, run=0, in_ready=0. Held until load_start or reset.
- busy=1 in CLEAR, LEN, DATA, CSUM.
- in_ready is a registered state decode; no combinational path from in_valid.
- Bubbles (in_valid=0) stall the FSM indefinitely; no timeout.
- Fetch:
  - in RUN, fetch_en at edge t -> fetch_data=RAM[fetch_addr], fetch_valid=1 at t+1.
  - fetch_en=0 -> fetch_valid=0 next cycle, fetch_data holds.
  - outside RUN fetch_en ignored: fetch_valid=0, fetch_data=HALT_OP.
- Back-to-back fetches every cycle sustained; fetch_addr wraps naturally (4-bit).
- Leaving RUN via load_start: fetch_valid drops the next cycle; no fetch is serviced in CLEAR.
- load_count saturates at N (max 16); retains value in RUN/ERROR until the next load_start.

Test Plan:
- Good load: load_start; after 16 CLEAR cycles send 03,95,23,A9,9F back-to-back -> run=1 one cycle after checksum byte, load_count=3, error=0. Fetch addr 0,1,2,3 -> fetch_data 95,23,A9,0F, each one cycle after request.
- Bad checksum: same stream with last byte 9E -> error=1, run=0, fetch_valid stays 0 on fetch_en. load_start then a good stream -> error cleared, run=1.
- Bad length: N=00 -> ERROR immediately. Repeat with N=11 (17) -> ERROR; no data byte accepted (in_ready=0 after length).
- Stalls and ignored start: in_valid toggled 1/0 per byte during DATA, load_start pulsed mid-DATA -> same final RAM and run as the gap-free case; load_start has no effect.
- Full program: N=10, 16 bytes 00..0F, checksum 88 -> run=1, load_count=16. Fetch addr 15 then 0 -> 0F then 00.
- Reset mid-load: pc_reset high during DATA after 2 bytes -> next cycle state IDLE, run=0, in_ready=0, load_count=0, error=0.
